timing_sequencer_ctrl: RTL and testbench
========================================

// Module: timing_sequencer_ctrl
// PURPOSE
//   Run/stop/single-step controller for the 4-bit timing-step counter.
//   Generates the current step O and the one-hot timing signals T0..Tn.
//   Supports a programmable terminal step, a clock prescaler and one-shot operation.
//   Sits between the front-panel/control inputs and the instruction-cycle logic that consumes T.
// PARAMETERS
//   CNT_W     4   width of step count O; T width is 2**CNT_W
//   PRESCALE  1   CLK cycles per step advance while running (>=1)
// PORTS
//   CLK      in   1          system clock, rising edge
//   RST_N    in   1          asynchronous, active-low reset
//   START    in   1          level/pulse: IDLE -> RUN
//   STOP     in   1          RUN -> IDLE, O holds
//   STEP     in   1          in IDLE: advance O by one step
//   CLR      in   1          synchronous clear of O and prescaler
//   MODE     in   1          0 = continuous, 1 = one-shot (stop after wrap)
//   LAST     in   CNT_W      terminal step; O wraps to 0 after LAST
//   O        out  CNT_W      current step (registered)
//   T        out  2**CNT_W   one-hot decode of O: T[O] = 1
//   RUNNING  out  1          1 while in RUN state
//   WRAP     out  1          one-cycle pulse on the edge O wraps LAST -> 0
// BEHAVIOUR
//   One clock (CLK); reset is asynchronous and active-low (RST_N).
//   Reset values: state=IDLE, O=0, T=1 (T0), RUNNING=0, WRAP=0, pcnt=0.
//   States:
//     IDLE -> RUN on START; pcnt <= 0.
//     RUN -> IDLE on STOP.
//     RUN -> IDLE on wrap when MODE=1.
//   Per-edge priority: CLR > STOP > START > STEP/advance.
//   CLR:
//     O <= 0, pcnt <= 0, WRAP <= 0; state unchanged.
//     No advance on that edge.
//   Advance rule (both RUN tick and IDLE STEP):
//     If O >= LAST: O <= 0 and WRAP <= 1.
//     Otherwise: O <= O+1 and WRAP <= 0.
//     O > LAST (LAST lowered mid-run) wraps to 0 on the next advance.
//     LAST = 0: O stays 0 and WRAP pulses on every advance.
//   RUN tick:
//     pcnt counts 0..PRESCALE-1; an advance occurs on the edge where pcnt == PRESCALE-1, and pcnt returns to 0.
//     First advance is PRESCALE edges after the edge that sampled START.
//   START while RUN: ignored; prescaler is not restarted.
//   STEP while RUN: ignored.
//   STOP:
//     Takes effect on the sampling edge; no advance on that edge.
//     O holds and pcnt <= 0.
//   One-shot (MODE=1):
//     The wrapping advance sets O=0, WRAP=1 and state IDLE on the same edge.
//     RUNNING=0 from the next cycle.
//   WRAP is registered and high for exactly one cycle per wrap.
//   T is combinational from registered O (1 << O); exactly one bit high at all times.
//   RUNNING is the registered state decode.
//   Reset asserted mid-run forces all reset values immediately (async).
//   The first post-reset edge behaves as from IDLE.
// TESTING
//   1. Reset, LAST=15, PRESCALE=1, MODE=0, pulse START ->
//      RUNNING=1 next cycle; O steps 1..15,0 on consecutive edges;
//      WRAP high only the cycle O=0 after 15; T tracks O.
//   2. LAST=5, MODE=1, START ->
//      O = 1,2,3,4,5,0; WRAP=1 with O=0; RUNNING drops the same cycle.
//      Further cycles hold O=0.
//   3. IDLE, three STEP pulses with LAST=1 ->
//      O = 1, 0 (WRAP=1), 1; STEP while RUN has no effect.
//   4. PRESCALE=3 build, START ->
//      O advances every 3rd edge; STOP at O=2 holds O=2;
//      a new START gives first advance 3 edges later.
//   5. Simultaneous CLR+STOP+START while RUN at O=7 ->
//      O=0, state RUN, WRAP=0.
//      LAST lowered from 15 to 3 at O=9 -> next advance O=0 with WRAP=1.
//   6. Assert RST_N=0 mid-run between edges ->
//      O=0, T=1, RUNNING=0, WRAP=0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/timing_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timing_sequencer_ctrl
// Description : Run/stop/single-step controller for the timing-step counter.
//               Produces the current step o and its one-hot decode t. It
//               supports a programmable terminal step (last), a run-time
//               prescaler and one-shot operation.
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               start    - IDLE -> RUN
//               stop     - RUN -> IDLE, o holds
//               step     - single advance while IDLE
//               clr      - synchronous clear of o and prescaler
//               mode     - 0 continuous, 1 one-shot (stop after wrap)
//               last     - terminal step, o wraps to 0 after it
//               o        - current step (registered)
//               t        - one-hot decode of o
//               running  - registered RUN state decode
//               wrap     - one-cycle pulse when o wraps to 0
// Revision    : 1.0 - initial release
// ============================================================================
module timing_sequencer_ctrl #(
    parameter int CNT_W    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  clr,
    input  logic                  mode,
    input  logic [CNT_W-1:0]      last,
    output logic [CNT_W-1:0]      o,
    output logic [(2**CNT_W)-1:0] t,
    output logic                  running,
    output logic                  wrap
);

    localparam int C_T_W    = 2**CNT_W;
    localparam int C_PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [C_PCNT_W-1:0] C_PMAX = C_PCNT_W'(PRESCALE - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    o_q, o_d;
    logic [C_PCNT_W-1:0] pcnt_q, pcnt_d;
    logic                wrap_q, wrap_d;
    logic                w_adv;

    // Next-state logic. The if/else chain encodes the per-edge priority
    // clr > stop > start > step/run tick.
    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        pcnt_d  = pcnt_q;
        wrap_d  = 1'b0;
        w_adv   = 1'b0;

        if (clr) begin
            o_d    = '0;
            pcnt_d = '0;
        end else if (stop) begin
            // stop while IDLE still blocks start/step on this edge
            if (state_q == S_RUN) begin
                state_d = S_IDLE;
                pcnt_d  = '0;
            end
        end else if (start && (state_q == S_IDLE)) begin
            state_d = S_RUN;
            pcnt_d  = '0;
        end else if (state_q == S_RUN) begin
            // start and step while running fall through to the normal tick
            if (pcnt_q == C_PMAX) begin
                pcnt_d = '0;
                w_adv  = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end else if (step) begin
            w_adv = 1'b1;
        end

        if (w_adv) begin
            // >= rather than == so an o left above a lowered last wraps too
            if (o_q >= last) begin
                o_d    = '0;
                wrap_d = 1'b1;
                if ((state_q == S_RUN) && mode) begin
                    state_d = S_IDLE;
                end
            end else begin
                o_d = o_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            o_q     <= '0;
            pcnt_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            pcnt_q  <= pcnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o       = o_q;
    assign t       = {{(C_T_W-1){1'b0}}, 1'b1} << o_q;
    assign running = (state_q == S_RUN);
    assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_timing_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_timing_sequencer_ctrl
// Description : Directed bench for timing_sequencer_ctrl. A PRESCALE=1
//               instance is driven from a vector table; a PRESCALE=3 instance
//               covers prescaled runs and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timing_sequencer_ctrl;

    typedef struct {
        logic       start;
        logic       stop;
        logic       step;
        logic       clr;
        logic       mode;
        logic [3:0] last;
        logic [3:0] exp_o;
        logic       exp_run;
        logic       exp_wrap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, step = 1'b0, clr = 1'b0, mode = 1'b0;
    logic [3:0]  last = 4'd15;
    logic [3:0]  o1, o3;
    logic [15:0] t1, t3;
    logic        run1, run3, wrap1, wrap3;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    timing_sequencer_ctrl #(.CNT_W(4), .PRESCALE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
        .clr(clr), .mode(mode), .last(last),
        .o(o1), .t(t1), .running(run1), .wrap(wrap1)
    );

    timing_sequencer_ctrl #(.CNT_W(4), .PRESCALE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
        .clr(clr), .mode(mode), .last(last),
        .o(o3), .t(t3), .running(run3), .wrap(wrap3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot(input logic [3:0] idx);
        logic [15:0] v;
        v = '0;
        v[idx] = 1'b1;
        return int'(v);
    endfunction

    function automatic void add(input logic st, input logic sp, input logic se,
                                input logic cl, input logic md, input logic [3:0] la,
                                input logic [3:0] eo, input logic er, input logic ew);
        vec_t v;
        v.start = st; v.stop = sp; v.step = se; v.clr = cl; v.mode = md;
        v.last = la; v.exp_o = eo; v.exp_run = er; v.exp_wrap = ew;
        vq.push_back(v);
    endfunction

    // Inputs are set after the active edge; outputs are checked 1 time unit
    // after the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; step = 0; clr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- table construction ----------------
        // 1: continuous run LAST=15
        add(1,0,0,0,0,15, 0,1,0);
        for (int i = 1; i <= 15; i++) add(0,0,0,0,0,15, 4'(i),1,0);
        add(0,0,0,0,0,15, 0,1,1);
        add(1,0,0,0,0,15, 1,1,0);          // start while running: ignored
        add(0,1,0,0,0,15, 1,0,0);          // stop holds o
        add(0,0,0,0,0,15, 1,0,0);
        // 2: one-shot LAST=5
        add(0,0,0,1,1,5, 0,0,0);           // clr in idle
        add(1,0,0,0,1,5, 0,1,0);
        for (int i = 1; i <= 5; i++) add(0,0,0,0,1,5, 4'(i),1,0);
        add(0,0,0,0,1,5, 0,0,1);
        add(0,0,0,0,1,5, 0,0,0);
        add(0,0,0,0,1,5, 0,0,0);
        // 3: single step LAST=1, then step while running
        add(0,0,1,0,0,1, 1,0,0);
        add(0,0,1,0,0,1, 0,0,1);
        add(0,0,1,0,0,1, 1,0,0);
        add(0,0,0,0,0,1, 1,0,0);
        add(1,0,1,0,0,1, 1,1,0);           // start beats step, no advance
        add(0,0,1,0,0,1, 0,1,1);           // run tick only, step ignored
        add(0,0,1,0,0,1, 1,1,0);
        add(0,1,0,0,0,1, 1,0,0);
        // LAST=0: o sticks at 0, wrap every advance
        add(0,0,1,0,0,0, 0,0,1);
        add(0,0,1,0,0,0, 0,0,1);
        add(0,0,0,0,0,0, 0,0,0);
        // 5: CLR+STOP+START while running, then LAST lowered mid-run
        add(1,0,0,0,0,15, 0,1,0);
        for (int i = 1; i <= 7; i++) add(0,0,0,0,0,15, 4'(i),1,0);
        add(1,1,0,1,0,15, 0,1,0);
        for (int i = 1; i <= 9; i++) add(0,0,0,0,0,15, 4'(i),1,0);
        add(0,0,0,0,0,3, 0,1,1);
        add(0,0,0,0,0,3, 1,1,0);
        add(0,1,0,0,0,3, 1,0,0);

        // ---------------- reset state ----------------
        rst_n = 0;
        #12;
        chk("rst_o",    int'(o1),   0);
        chk("rst_t",    int'(t1),   1);
        chk("rst_run",  int'(run1), 0);
        chk("rst_wrap", int'(wrap1), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // ---------------- table application ----------------
        foreach (vq[k]) begin
            start = vq[k].start; stop = vq[k].stop; step = vq[k].step;
            clr = vq[k].clr; mode = vq[k].mode; last = vq[k].last;
            tick();
            chk($sformatf("v%0d_o", k),    int'(o1),    int'(vq[k].exp_o));
            chk($sformatf("v%0d_t", k),    int'(t1),    onehot(vq[k].exp_o));
            chk($sformatf("v%0d_run", k),  int'(run1),  int'(vq[k].exp_run));
            chk($sformatf("v%0d_wrap", k), int'(wrap1), int'(vq[k].exp_wrap));
        end
        idle_inputs();

        // ---------------- 4: PRESCALE=3 instance ----------------
        rst_n = 0;
        #2;
        rst_n = 1;
        mode = 0; last = 15;
        start = 1;
        tick();
        start = 0;
        chk("p3_start_run", int'(run3), 1);
        chk("p3_start_o",   int'(o3),   0);
        begin
            logic [3:0] exp_seq [6];
            exp_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
            for (int i = 0; i < 6; i++) begin
                tick();
                chk($sformatf("p3_run%0d_o", i), int'(o3), int'(exp_seq[i]));
            end
        end
        stop = 1;
        tick();
        stop = 0;
        chk("p3_stop_o",   int'(o3),   2);
        chk("p3_stop_run", int'(run3), 0);
        tick();
        tick();
        chk("p3_hold_o", int'(o3), 2);
        start = 1;
        tick();
        start = 0;
        chk("p3_restart_run", int'(run3), 1);
        tick();
        chk("p3_re1_o", int'(o3), 2);
        tick();
        chk("p3_re2_o", int'(o3), 2);
        tick();
        chk("p3_re3_o", int'(o3), 3);

        // ---------------- 6: asynchronous reset mid-run ----------------
        tick();
        tick();
        tick();
        chk("p3_pre_rst_o", int'(o3), 4);
        #3;
        rst_n = 0;
        #1;
        chk("arst_o",    int'(o3),   0);
        chk("arst_t",    int'(t3),   1);
        chk("arst_run",  int'(run3), 0);
        chk("arst_wrap", int'(wrap3), 0);
        chk("arst_run1", int'(run1), 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("post_rst_o",   int'(o3),   0);
        chk("post_rst_run", int'(run3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
